// File: rtl/instr_pkg.sv
// Shared instruction-format constants for the fetch/decode path.
// Field layout of an instruction word (LSB first):
//   op [5:0], dst [11:6], src1 [17:12], src2 [23:18],
//   jump [33:18] (beq target), imm [WIDTH-1:18] (addi immediate).
package instr_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned REG_W    = 6;
  localparam int unsigned JUMP_W   = 16;

  localparam int unsigned OP_LSB   = 0;
  localparam int unsigned DST_LSB  = 6;
  localparam int unsigned SRC1_LSB = 12;
  localparam int unsigned SRC2_LSB = 18;
  localparam int unsigned JUMP_LSB = 18;
  localparam int unsigned IMM_LSB  = 18;

  // Smallest word width that still holds the full jump field.
  localparam int unsigned MIN_WIDTH = JUMP_LSB + JUMP_W;

endpackage

// File: rtl/instr_field_slice.sv
// Combinational field extractor for one instruction word.
// When valid is low every output is forced to zero so stale words never leak.
// Ports:
//   instr   in  WIDTH       raw instruction word
//   valid   in  1           word is meaningful
//   instr_g out WIDTH       gated word
//   op      out OP_W        opcode
//   dst     out REG_W       R-type/addi dst, beq src1
//   src1    out REG_W       R-type/addi src1, beq src2
//   src2    out REG_W       R-type src2
//   jump    out JUMP_W      beq jump address
//   imm     out WIDTH-18    addi immediate, unsigned
module instr_field_slice
  import instr_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0]         instr,
  input  logic                     valid,
  output logic [WIDTH-1:0]         instr_g,
  output logic [OP_W-1:0]          op,
  output logic [REG_W-1:0]         dst,
  output logic [REG_W-1:0]         src1,
  output logic [REG_W-1:0]         src2,
  output logic [JUMP_W-1:0]        jump,
  output logic [WIDTH-IMM_LSB-1:0] imm
);

  always_comb begin
    instr_g = valid ? instr : '0;
    op      = instr_g[OP_LSB   +: OP_W];
    dst     = instr_g[DST_LSB  +: REG_W];
    src1    = instr_g[SRC1_LSB +: REG_W];
    src2    = instr_g[SRC2_LSB +: REG_W];
    jump    = instr_g[JUMP_LSB +: JUMP_W];
    imm     = instr_g[WIDTH-1:IMM_LSB];
  end

endmodule

// File: rtl/instr_queue.sv
// Buffered instruction register: circular FIFO of DEPTH words between
// instruction memory and decode, with the head word pre-sliced into fields.
// Optional macro INSTR_QUEUE_TRACE_EN enables a simulation-only trace of
// pops and flushes; port behaviour is unchanged either way.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_instr     producer offers a word
//   in_ready              space available (count < DEPTH, independent of pop)
//   out_valid/out_ready   head handshake
//   out_instr, out_op, out_dst, out_src1, out_src2, out_jump, out_imm
//                         head word and its fields, zero when empty
//   flush                 synchronous discard of all buffered words
//   level                 number of buffered words
module instr_queue
  import instr_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_instr,
  output logic [OP_W-1:0]          out_op,
  output logic [REG_W-1:0]         out_dst,
  output logic [REG_W-1:0]         out_src1,
  output logic [REG_W-1:0]         out_src2,
  output logic [JUMP_W-1:0]        out_jump,
  output logic [WIDTH-IMM_LSB-1:0] out_imm,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  assign in_ready  = (count_q < DepthCnt);
  assign out_valid = (count_q != '0);
  assign level     = count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally on overflow.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; output gating hides stale entries.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= in_instr;
    end
  end

  instr_field_slice #(
    .WIDTH (WIDTH)
  ) u_slice (
    .instr   (mem_q[rd_ptr_q]),
    .valid   (out_valid),
    .instr_g (out_instr),
    .op      (out_op),
    .dst     (out_dst),
    .src1    (out_src1),
    .src2    (out_src2),
    .jump    (out_jump),
    .imm     (out_imm)
  );

`ifdef INSTR_QUEUE_TRACE_EN
  always @(posedge clk) begin
    if (!rst && flush) begin
      $display("instr_queue: flush %0d", level);
    end else if (!rst && pop) begin
      $display("%0t instr_queue: op=%0d dst=%0d src1=%0d src2=%0d jump=%0d imm=%0d",
               $time, out_op, out_dst, out_src1, out_src2, out_jump, out_imm);
    end
  end
`else
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (WIDTH=64, DEPTH=4).
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_instr;
  logic [5:0]  out_op, out_dst, out_src1, out_src2;
  logic [15:0] out_jump;
  logic [45:0] out_imm;
  logic        flush;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;

  instr_queue #(
    .WIDTH (64),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_op    (out_op),
    .out_dst   (out_dst),
    .out_src1  (out_src1),
    .out_src2  (out_src2),
    .out_jump  (out_jump),
    .out_imm   (out_imm),
    .flush     (flush),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] w);
    in_valid = 1'b1;
    in_instr = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [63:0] w);
    check(tag, out_instr, w);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  logic [63:0] words [4];
  logic [63:0] s;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (3) step();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_instr", out_instr, 64'd0);
    rst = 1'b0;
    step();

    // Single push, fields sliced one cycle later.
    push_word(64'h0000_0000_0030_2083);
    check("p1_valid", 64'(out_valid), 64'd1);
    check("p1_op", 64'(out_op), 64'd3);
    check("p1_dst", 64'(out_dst), 64'd2);
    check("p1_src1", 64'(out_src1), 64'd2);
    check("p1_src2", 64'(out_src2), 64'd12);
    check("p1_jump", 64'(out_jump), 64'd12);
    check("p1_imm", 64'(out_imm), 64'd12);
    check("p1_level", 64'(level), 64'd1);
    pop_check("p1_pop", 64'h0000_0000_0030_2083);
    check("p1_empty", 64'(level), 64'd0);

    // Flush on empty queue returns pointers to 0.
    flush = 1'b1; step(); flush = 1'b0;

    // Fill to full, attempt a fifth push, drain in order.
    words[0] = 64'hA000_0000_0000_0001;
    words[1] = 64'hA000_0000_0000_0002;
    words[2] = 64'hA000_0000_0000_0003;
    words[3] = 64'hA000_0000_0000_0004;
    for (int i = 0; i < 4; i++) push_word(words[i]);
    check("full_level", 64'(level), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    push_word(64'hDEAD_DEAD_DEAD_DEAD);
    check("full_no_5th", 64'(level), 64'd4);
    // Full queue refuses a push even while popping.
    in_valid = 1'b1; in_instr = 64'hBEEF; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("full_pop_no_push", 64'(level), 64'd3);
    for (int i = 1; i < 4; i++) pop_check($sformatf("drain%0d", i), words[i]);
    check("drain_level", 64'(level), 64'd0);
    check("drain_gated", out_instr, 64'd0);

    // Steady stream at level 2.
    push_word(64'h1111_0000_0000_0000);
    push_word(64'h1111_0000_0000_0001);
    for (int i = 0; i < 20; i++) begin
      s = 64'h1111_0000_0000_0000 + 64'(i);
      check($sformatf("stream%0d", i), out_instr, s);
      in_valid = 1'b1; out_ready = 1'b1;
      in_instr = 64'h1111_0000_0000_0000 + 64'(i + 2);
      step();
      check($sformatf("stream_lvl%0d", i), 64'(level), 64'd2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    pop_check("stream_tail0", 64'h1111_0000_0000_0014);
    pop_check("stream_tail1", 64'h1111_0000_0000_0015);
    check("stream_empty", 64'(level), 64'd0);

    // Flush beats push and pop in the same cycle.
    push_word(64'h2222_0000_0000_0000);
    push_word(64'h2222_0000_0000_0001);
    push_word(64'h2222_0000_0000_0002);
    check("fl_pre_level", 64'(level), 64'd3);
    flush = 1'b1; in_valid = 1'b1; in_instr = 64'h2222_0000_0000_0003; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("fl_level", 64'(level), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    push_word(64'h3333_0000_0000_0007);
    check("fl_post_level", 64'(level), 64'd1);
    check("fl_post_head", out_instr, 64'h3333_0000_0000_0007);
    pop_check("fl_post_pop", 64'h3333_0000_0000_0007);

    // Asynchronous reset mid-cycle.
    push_word(64'h4444_0000_0000_0000);
    push_word(64'h4444_0000_0000_0001);
    check("ar_pre_level", 64'(level), 64'd2);
    #1 rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_level", 64'(level), 64'd0);
    check("ar_instr", out_instr, 64'd0);
    #1 rst = 1'b0;
    step();
    push_word(64'h5555_0000_0000_0009);
    check("ar_post_level", 64'(level), 64'd1);
    check("ar_post_head", out_instr, 64'h5555_0000_0000_0009);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
